// File: rtl/lbm_step_scheduler.sv
// Sequencer for one D2Q9 lattice-Boltzmann time step per pass over the grid:
// per node it loads moments, waits on the divider, collides, then streams nine directions.
module lbm_step_scheduler #(
   parameter int NX            = 16,
   parameter int NY            = 16,
   parameter int ADDRESS_WIDTH = $clog2(NX * NY),
   parameter int ITER_WIDTH    = 16
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [ITER_WIDTH-1:0]    num_iters,
   input  logic                     div_valid,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] node_addr,
   output logic                     div_start,
   output logic                     LD_EN_MOM,
   output logic                     LD_EN_FEQ,
   output logic                     WE_fout_mem,
   output logic                     WE_fin_mem,
   output logic [3:0]               stream_dir,
   output logic [ADDRESS_WIDTH-1:0] stream_addr,
   output logic [ITER_WIDTH-1:0]    iter_count
);

   localparam int XW = (NX > 1) ? $clog2(NX) : 1;
   localparam int YW = (NY > 1) ? $clog2(NY) : 1;

   typedef enum logic [3:0] {
      IDLE,
      READ,
      DIV_START,
      DIV_WAIT,
      EQUIL,
      COLLIDE,
      STREAM,
      ADVANCE,
      DONE
   } state_t;

   state_t state, state_next;

   logic [ITER_WIDTH-1:0] iters_target;
   logic [XW-1:0]         x_pos, x_next;
   logic [YW-1:0]         y_pos, y_next;
   logic                  last_node, last_iter, abort_run;
   logic                  dx_pos, dx_neg, dy_pos, dy_neg;

   assign last_node = (x_pos == XW'(NX - 1)) && (y_pos == YW'(NY - 1));
   assign last_iter = ((iter_count + 1'b1) == iters_target);
   assign abort_run = abort && (state != IDLE);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Abort overrides every other decision, including the divider handshake and end-of-run.
   always_comb begin
      state_next  = state;
      busy        = 1'b0;
      done        = 1'b0;
      div_start   = 1'b0;
      LD_EN_MOM   = 1'b0;
      LD_EN_FEQ   = 1'b0;
      WE_fout_mem = 1'b0;
      WE_fin_mem  = 1'b0;
      if (abort_run) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:      if (start) state_next = (num_iters == '0) ? DONE : READ;
            READ:      state_next = DIV_START;
            DIV_START: state_next = DIV_WAIT;
            DIV_WAIT:  if (div_valid) state_next = EQUIL;
            EQUIL:     state_next = COLLIDE;
            COLLIDE:   state_next = STREAM;
            STREAM:    if (stream_dir == 4'd8) state_next = ADVANCE;
            ADVANCE:   state_next = (last_node && last_iter) ? DONE : READ;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
         endcase
      end
      busy        = (state != IDLE);
      done        = (state == DONE);
      div_start   = (state == DIV_START);
      LD_EN_MOM   = (state == READ);
      LD_EN_FEQ   = (state == EQUIL);
      WE_fout_mem = (state == COLLIDE);
      WE_fin_mem  = (state == STREAM);
   end

   // x/y are tracked beside node_addr so neighbour wrap needs no division.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         node_addr    <= '0;
         x_pos        <= '0;
         y_pos        <= '0;
         iter_count   <= '0;
         iters_target <= '0;
         stream_dir   <= '0;
      end else if (abort_run) begin
         node_addr  <= '0;
         x_pos      <= '0;
         y_pos      <= '0;
         iter_count <= '0;
         stream_dir <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  iters_target <= num_iters;
                  iter_count   <= '0;
                  node_addr    <= '0;
                  x_pos        <= '0;
                  y_pos        <= '0;
               end
            end
            STREAM: begin
               stream_dir <= (stream_dir == 4'd8) ? 4'd0 : stream_dir + 4'd1;
            end
            ADVANCE: begin
               if (last_node) begin
                  node_addr  <= '0;
                  x_pos      <= '0;
                  y_pos      <= '0;
                  iter_count <= iter_count + 1'b1;
               end else begin
                  node_addr <= node_addr + 1'b1;
                  if (x_pos == XW'(NX - 1)) begin
                     x_pos <= '0;
                     y_pos <= y_pos + 1'b1;
                  end else begin
                     x_pos <= x_pos + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // D2Q9 offsets, applied with periodic wrap on both axes.
   always_comb begin
      dx_pos = 1'b0;
      dx_neg = 1'b0;
      dy_pos = 1'b0;
      dy_neg = 1'b0;
      case (stream_dir)
         4'd1: dx_pos = 1'b1;
         4'd2: dy_pos = 1'b1;
         4'd3: dx_neg = 1'b1;
         4'd4: dy_neg = 1'b1;
         4'd5: begin dx_pos = 1'b1; dy_pos = 1'b1; end
         4'd6: begin dx_neg = 1'b1; dy_pos = 1'b1; end
         4'd7: begin dx_neg = 1'b1; dy_neg = 1'b1; end
         4'd8: begin dx_pos = 1'b1; dy_neg = 1'b1; end
         default: ;
      endcase
      x_next = x_pos;
      if (dx_pos) x_next = (x_pos == XW'(NX - 1)) ? '0 : x_pos + 1'b1;
      else if (dx_neg) x_next = (x_pos == '0) ? XW'(NX - 1) : x_pos - 1'b1;
      y_next = y_pos;
      if (dy_pos) y_next = (y_pos == YW'(NY - 1)) ? '0 : y_pos + 1'b1;
      else if (dy_neg) y_next = (y_pos == '0) ? YW'(NY - 1) : y_pos - 1'b1;
   end

   assign stream_addr = ADDRESS_WIDTH'(y_next) * ADDRESS_WIDTH'(NX) + ADDRESS_WIDTH'(x_next);

endmodule
